// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
//
// Purpose: encodings for the memory access op, arbiter state and requester id.
// Ports: none (package).

package dmem_arb_pkg;

  localparam int unsigned AW_DEF   = 12;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned SL_OP_W  = 4;

  // Store/load op as seen by data_memory; 0 means "no access".
  typedef enum logic [SL_OP_W-1:0] {
    SL_NONE = 4'd0,
    SL_SB   = 4'd1,
    SL_SH   = 4'd2,
    SL_SW   = 4'd3,
    SL_LB   = 4'd4,
    SL_LH   = 4'd5,
    SL_LW   = 4'd6,
    SL_LBU  = 4'd7,
    SL_LHU  = 4'd8
  } sl_op_e;

  typedef enum logic {
    FREE  = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } port_id_e;

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// rtl/dmem_arb_rsp_pipe.sv - read response tracker routing memory data back to its owner
//
// Purpose: MEM_LAT-deep shift register of {valid, port id}; the last stage
// selects which requester sees mem_rdata_i. Read data is forced to 0 whenever
// the corresponding rvalid is low.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   issue_i                a read was accepted this cycle
//   issue_port_i           owner of that read (0 = port 0, 1 = port 1)
//   mem_rdata_i            data returned by data_memory
//   p0_rvalid_o/p0_rdata_o response to port 0
//   p1_rvalid_o/p1_rdata_o response to port 1

module dmem_arb_rsp_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          issue_i,
  input  logic          issue_port_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          p0_rvalid_o,
  output logic [DW-1:0] p0_rdata_o,
  output logic          p1_rvalid_o,
  output logic [DW-1:0] p1_rdata_o
);

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] pid_q;
  logic               out_vld;
  port_id_e           out_port;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      pid_q <= '0;
    end else begin
      vld_q[0] <= issue_i;
      pid_q[0] <= issue_port_i;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  // Gating with rst_ni drops a response that would land in a reset cycle.
  assign out_vld  = vld_q[MEM_LAT-1] & rst_ni;
  assign out_port = port_id_e'(pid_q[MEM_LAT-1]);

  assign p0_rvalid_o = out_vld & (out_port == P0);
  assign p1_rvalid_o = out_vld & (out_port == P1);
  assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the single data_memory port
//
// Purpose: grants at most one of port 0 (core MEM stage) and port 1
// (debug/boot loader) per cycle, drives data_memory from the winner and routes
// read data back after MEM_LAT cycles. Port 1 may lock the bus for bursts.
// Default arbitration: port 0 priority, with port 1 forced through after
// MAX_WAIT refused cycles. Defining DMEM_ARB_RR_EN switches the FREE-state
// choice to round-robin on a last-granted pointer and removes the wait counter.
// Ports:
//   clk_i, rst_ni                           clock, synchronous active-low reset
//   pN_req_i/we_i/addr_i/wdata_i/sl_op_i/ls_op_i  requester N access fields
//   pN_gnt_o                                 request N accepted this cycle
//   pN_rvalid_o/pN_rdata_o                   read response to requester N
//   p1_lock_i                                keep bus for port 1 after this grant
//   mem_addr_o/wdata_o/wren_o/sl_op_o/ls_op_o  to data_memory
//   mem_rdata_i                              from data_memory

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          p0_req_i,
  input  logic          p0_we_i,
  input  logic [AW-1:0] p0_addr_i,
  input  logic [DW-1:0] p0_wdata_i,
  input  logic [3:0]    p0_sl_op_i,
  input  logic          p0_ls_op_i,
  output logic          p0_gnt_o,
  output logic          p0_rvalid_o,
  output logic [DW-1:0] p0_rdata_o,
  input  logic          p1_req_i,
  input  logic          p1_we_i,
  input  logic [AW-1:0] p1_addr_i,
  input  logic [DW-1:0] p1_wdata_i,
  input  logic [3:0]    p1_sl_op_i,
  input  logic          p1_ls_op_i,
  input  logic          p1_lock_i,
  output logic          p1_gnt_o,
  output logic          p1_rvalid_o,
  output logic [DW-1:0] p1_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wren_o,
  output logic [3:0]    mem_sl_op_o,
  output logic          mem_ls_op_o,
  input  logic [DW-1:0] mem_rdata_i
);

  arb_state_e state_q, state_d;
  logic       gnt0, gnt1;
  logic       p1_wins;   // port 1 takes the bus in FREE state this cycle

`ifdef DMEM_ARB_RR_EN
  port_id_e last_q;

  // Reset to P1 so the first contention goes to port 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= P1;
    end else if (gnt0) begin
      last_q <= P0;
    end else if (gnt1) begin
      last_q <= P1;
    end
  end

  assign p1_wins = p1_req_i & (~p0_req_i | (last_q == P0));
`else
  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] wait_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (!p1_req_i || gnt1) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign p1_wins = p1_req_i & (~p0_req_i | (wait_cnt_q == WCW'(MAX_WAIT)));
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants are withheld while rst_ni is low so nothing reaches memory in reset.
  // In LOCK1 port 0 is never granted, so a lock release leaves port 0 waiting
  // until the following cycle.
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (rst_ni) begin
      case (state_q)
        FREE: begin
          if (p1_wins) begin
            gnt1 = 1'b1;
            if (p1_lock_i) begin
              state_d = LOCK1;
            end
          end else if (p0_req_i) begin
            gnt0 = 1'b1;
          end
        end
        LOCK1: begin
          if (!p1_req_i) begin
            state_d = FREE;
          end else begin
            gnt1 = 1'b1;
            if (!p1_lock_i) begin
              state_d = FREE;
            end
          end
        end
        default: state_d = FREE;
      endcase
    end
  end

  assign p0_gnt_o = gnt0;
  assign p1_gnt_o = gnt1;

  always_comb begin
    mem_addr_o  = p0_addr_i;
    mem_wdata_o = '0;
    mem_wren_o  = 1'b0;
    mem_sl_op_o = SL_NONE;
    mem_ls_op_o = 1'b0;
    if (gnt1) begin
      mem_addr_o  = p1_addr_i;
      mem_wdata_o = p1_wdata_i;
      mem_wren_o  = p1_we_i;
      mem_sl_op_o = p1_sl_op_i;
      mem_ls_op_o = p1_ls_op_i;
    end else if (gnt0) begin
      mem_addr_o  = p0_addr_i;
      mem_wdata_o = p0_wdata_i;
      mem_wren_o  = p0_we_i;
      mem_sl_op_o = p0_sl_op_i;
      mem_ls_op_o = p0_ls_op_i;
    end
  end

  logic rd_issue;
  assign rd_issue = (gnt0 & ~p0_we_i) | (gnt1 & ~p1_we_i);

  dmem_arb_rsp_pipe #(
    .DW      (DW),
    .MEM_LAT (MEM_LAT)
  ) u_rsp_pipe (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .issue_i      (rd_issue),
    .issue_port_i (gnt1),
    .mem_rdata_i  (mem_rdata_i),
    .p0_rvalid_o  (p0_rvalid_o),
    .p0_rdata_o   (p0_rdata_o),
    .p1_rvalid_o  (p1_rvalid_o),
    .p1_rdata_o   (p1_rdata_o)
  );

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (12-bit byte address, 32-bit data, sl_op/ls_op access encoding) between two requesters:
  - port 0: pipeline MEM stage (core).
  - port 1: debug/boot loader.
- Sits between both requesters and the data_memory instance.
- Issues at most one access per cycle, routes read data back to its owner after a fixed latency, and supports locked bursts from port 1.
- Port 1 has a bounded wait under fixed priority.

Parameters:
- AW, 12, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from accepted read to valid mem_rdata_i (>=1).
- MAX_WAIT, 8, cycles port 1 may be refused before a forced grant (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- p0_req_i  in  1  port 0 access request.
- p0_we_i  in  1  port 0 write enable.
- p0_addr_i  in  AW  port 0 address.
- p0_wdata_i  in  DW  port 0 write data.
- p0_sl_op_i  in  4  port 0 store/load op (SB=1,SH=2,SW=3,LB=4,LH=5,LW=6,LBU=7,LHU=8).
- p0_ls_op_i  in  1  port 0 load/store qualifier.
- p0_gnt_o  out  1  port 0 request accepted this cycle.
- p0_rvalid_o  out  1  port 0 read data valid.
- p0_rdata_o  out  DW  port 0 read data.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_sl_op_i, p1_ls_op_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o  same as port 0.
- p1_lock_i  in  1  hold bus after this grant.
- mem_addr_o  out  AW  to data_memory.
- mem_wdata_o  out  DW  to data_memory.
- mem_wren_o  out  1  to data_memory.
- mem_sl_op_o  out  4  to data_memory.
- mem_ls_op_o  out  1  to data_memory.
- mem_rdata_i  in  DW  from data_memory.

Behaviour:
- Clock clk_i; reset rst_ni is synchronous and active-low. All state is updated on the rising edge of clk_i.
- Handshake:
  - A request is accepted on a posedge where req and gnt are both 1.
  - gnt is combinational from req and the registered state.
  - A requester holds all fields stable until granted.
- Read/write completion:
  - An accepted read (we=0) produces exactly one rvalid pulse to its owner exactly MEM_LAT cycles later.
  - rdata_o = mem_rdata_i in that cycle; rdata_o is 0 when rvalid is 0.
  - A write completes on grant and produces no rvalid.
- Memory mux:
  - The granted port's fields drive mem_*_o.
  - With no grant: mem_wren_o=0, mem_sl_op_o=0, mem_ls_op_o=0, mem_addr_o=p0_addr_i, mem_wdata_o=0.
- State machine (state): FREE, LOCK1.
  - FREE, priority rule:
    - port 0 wins when both request;
    - exception: port 1 wins if wait_cnt==MAX_WAIT.
  - FREE->LOCK1 when port 1 is granted with p1_lock_i=1.
  - LOCK1: only port 1 may be granted; p0_gnt_o=0.
  - LOCK1->FREE on a port 1 grant with p1_lock_i=0, or when p1_req_i=0.
- Starvation counter (wait_cnt):
  - increments each cycle p1_req_i=1 and p1_gnt_o=0;
  - clears on a port 1 grant or when p1_req_i=0;
  - saturates at MAX_WAIT.
- Back-to-back:
  - one grant per cycle, fully pipelined;
  - consecutive reads from alternating ports return in issue order.
- Reset asserted:
  - state=FREE, wait_cnt=0, response pipeline cleared;
  - all gnt_o=0, rvalid_o=0, mem_wren_o=0.
- Reset mid-operation: in-flight reads are dropped and never produce rvalid; a locked burst is released.
- Simultaneous events: when a lock release and a port 0 request occur in the same cycle, port 0 may be granted only from the next cycle.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - FREE-state arbitration is round-robin on a registered last-granted pointer (reset value: port 1, so port 0 wins the first contention);
  - wait_cnt is not instantiated;
  - lock behaviour is unchanged.
- Undefined: fixed priority with the starvation counter, as above.

Decomposition:
- Package dmem_arb_pkg:
  - sl_op_e encodings;
  - arb_state_e {FREE, LOCK1};
  - port_id_e {P0, P1};
  - default widths.
- Sub-module dmem_arb_rsp_pipe:
  - MEM_LAT-deep shift register of {valid, port_id};
  - generates p0/p1 rvalid and gated rdata.

Test Plan:
- Contention: p0 and p1 request reads together at 0x010 and 0x020.
  - -> p0_gnt=1, p1_gnt=0.
  - -> next cycle p1 granted.
  - -> p0_rvalid at t+1 (MEM_LAT=1), then p1_rvalid at t+2 with matching data.
- Starvation: p0 requests every cycle, p1 requests continuously.
  - -> p1 granted on the 9th cycle (MAX_WAIT=8).
  - -> wait_cnt back to 0.
- Lock burst: p1 writes 0x100..0x10C with lock=1 and the last with lock=0, while p0 requests throughout.
  - -> p0_gnt=0 for 4 cycles.
  - -> p0 granted in the cycle after the last p1 write.
- Write: p0 SW 0xDEADBEEF to 0x400.
  - -> mem_wren_o=1, mem_sl_op_o=3 for exactly one cycle.
  - -> no rvalid.
- Reset mid-read: grant p0 read, assert rst_ni=0 the next edge.
  - -> no p0_rvalid; state FREE; all outputs 0.
- With DMEM_ARB_RR_EN: p0 and p1 request continuously.
  - -> grants alternate P0,P1,P0,P1.
